// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The pipeline (master) drives
// the decode/execute status and MMIO handshake; the controller (slave)
// returns stall/flush/bubble controls, its state and performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Decode stage
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  // Execute stage
  logic             ex_valid;
  logic [4:0]       ex_wb_addr;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             ex_mmio_req;
  // MMIO handshake
  logic             mmio_ready;
  // Controls back to the pipeline
  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             flush_idex;
  logic             wb_bubble;
  logic             mmio_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_wb_addr, ex_is_load, ex_redirect, ex_mmio_req,
           mmio_ready,
    input  stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid,
           flush_idex, wb_bubble, mmio_err, state_o, cnt_stall, cnt_flush
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_wb_addr, ex_is_load, ex_redirect, ex_mmio_req,
           mmio_ready,
    output stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid,
           flush_idex, wb_bubble, mmio_err, state_o, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencing controller: load-use stalls, redirect flushes
// (flush cycle plus one FLUSH cycle for the stale BRAM fetch) and MMIO wait
// stalls with an optional timeout. Stall/flush/bubble outputs are Mealy;
// state, wait counter, mmio_err and the saturating counters are registered.
module hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MMIO_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    MMIO_WAIT = 2'd2
  } state_t;

  // Wait counter only has to reach MMIO_TIMEOUT-1; with the timeout disabled
  // it may wrap freely because nothing compares it.
  localparam int WCNT_W = (MMIO_TIMEOUT > 1) ? $clog2(MMIO_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST =
    WCNT_W'((MMIO_TIMEOUT == 0) ? 0 : MMIO_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  cnt_stall, cnt_flush;
  logic              mmio_err;

  logic ld_use, mmio_block, redir, timeout_hit;
  logic stall_pc, stall_ifid, stall_idex, bubble_idex;
  logic flush_ifid, flush_idex, wb_bubble;
  logic flush_accept, err_set;

  assign ld_use = hz.ex_valid & hz.ex_is_load & (hz.ex_wb_addr != 5'd0) &
                  hz.id_valid &
                  ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_wb_addr)) |
                   (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_wb_addr)));
  assign mmio_block  = hz.ex_valid & hz.ex_mmio_req & ~hz.mmio_ready;
  assign redir       = hz.ex_valid & hz.ex_redirect;
  assign timeout_hit = (MMIO_TIMEOUT != 0) && (wcnt == WCNT_LAST);

  // Next state and Mealy controls; priority is MMIO block, redirect, load-use.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
    state_nxt    = state;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    wb_bubble    = 1'b0;
    flush_accept = 1'b0;
    err_set      = 1'b0;
    case (state)
      RUN: begin
        if (mmio_block) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          wb_bubble  = 1'b1;
          state_nxt  = MMIO_WAIT;
        end else if (redir) begin
          flush_ifid   = 1'b1;
          flush_idex   = 1'b1;
          flush_accept = 1'b1;
          state_nxt    = FLUSH;
        end else if (ld_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
      end
      FLUSH: begin
        // Kills the fetch that was already in flight from the old PC.
        flush_ifid = 1'b1;
        state_nxt  = RUN;
      end
      MMIO_WAIT: begin
        if (hz.mmio_ready) begin
          state_nxt = RUN;
          if (ld_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end else if (timeout_hit) begin
          // Give up: the instruction retires with undefined load data.
          err_set   = 1'b1;
          state_nxt = RUN;
        end else begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          wb_bubble  = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Wait counter: held at zero outside MMIO_WAIT, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wcnt <= '0;
    else if (state == MMIO_WAIT) wcnt <= wcnt + 1'b1;
    else                         wcnt <= '0;
  end

  // Registered timeout pulse, visible in the first RUN cycle after the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mmio_err <= 1'b0;
    else        mmio_err <= err_set;
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (stall_pc && (cnt_stall != '1))     cnt_stall <= cnt_stall + 1'b1;
      if (flush_accept && (cnt_flush != '1)) cnt_flush <= cnt_flush + 1'b1;
    end
  end

  assign hz.stall_pc    = stall_pc;
  assign hz.stall_ifid  = stall_ifid;
  assign hz.stall_idex  = stall_idex;
  assign hz.bubble_idex = bubble_idex;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.flush_idex  = flush_idex;
  assign hz.wb_bubble   = wb_bubble;
  assign hz.mmio_err    = mmio_err;
  assign hz.state_o     = state;
  assign hz.cnt_stall   = cnt_stall;
  assign hz.cnt_flush   = cnt_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (CNT_W=4, MMIO_TIMEOUT=8). The driver
// applies one directed vector per cycle just after the rising edge and pushes
// its hand-computed response; the monitor pops and compares at the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ex_valid;
    logic [4:0] wb;
    logic       ld;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  // ctl = {stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid, flush_idex, wb_bubble}
  typedef struct packed {
    logic [6:0] ctl;
    logic       err;
    logic [1:0] st;
    logic [3:0] cs;
    logic [3:0] cf;
  } resp_t;

  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_LU   = 7'b110_1000;
  localparam logic [6:0] C_MMIO = 7'b111_0001;
  localparam logic [6:0] C_RDR  = 7'b000_0110;
  localparam logic [6:0] C_FL   = 7'b000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  resp_t exp_q[$];
  string name_q[$];

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.CNT_W(4), .MMIO_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t s_idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_lu(logic [4:0] wb, logic [4:0] rs1, logic u1,
                                 logic [4:0] rs2, logic u2);
    stim_t s = s_idle();
    s.ex_valid = 1'b1;
    s.ld       = 1'b1;
    s.wb       = wb;
    s.id_valid = 1'b1;
    s.rs1      = rs1;
    s.u1       = u1;
    s.rs2      = rs2;
    s.u2       = u2;
    return s;
  endfunction

  function automatic stim_t s_redir(logic with_lu);
    stim_t s = with_lu ? s_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1) : s_idle();
    s.ex_valid = 1'b1;
    s.redir    = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_mmio(logic rdy, logic dep);
    stim_t s = s_idle();
    s.ex_valid = 1'b1;
    s.mreq     = 1'b1;
    s.ld       = 1'b1;
    s.wb       = 5'd7;
    s.mrdy     = rdy;
    if (dep) begin
      s.id_valid = 1'b1;
      s.rs1      = 5'd7;
      s.u1       = 1'b1;
    end
    return s;
  endfunction

  function automatic resp_t mk(logic [6:0] ctl, logic err, logic [1:0] st,
                               int cs, int cf);
    resp_t r;
    r.ctl = ctl;
    r.err = err;
    r.st  = st;
    r.cs  = 4'(cs);
    r.cf  = 4'(cf);
    return r;
  endfunction

  function automatic int sat(int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Apply one vector for the coming cycle and queue its expected response.
  task automatic step(input string name, input stim_t s, input resp_t e);
    @(posedge clk);
    #1;
    rst_n           = s.rst_n;
    bus.id_valid    = s.id_valid;
    bus.id_rs1_addr = s.rs1;
    bus.id_rs2_addr = s.rs2;
    bus.id_uses_rs1 = s.u1;
    bus.id_uses_rs2 = s.u2;
    bus.ex_valid    = s.ex_valid;
    bus.ex_wb_addr  = s.wb;
    bus.ex_is_load  = s.ld;
    bus.ex_redirect = s.redir;
    bus.ex_mmio_req = s.mreq;
    bus.mmio_ready  = s.mrdy;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic check(input string name, input resp_t got, input resp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ctl=%b err=%b st=%0d cs=%0d cf=%0d, expected ctl=%b err=%b st=%0d cs=%0d cf=%0d",
               name, got.ctl, got.err, got.st, got.cs, got.cf,
               exp.ctl, exp.err, exp.st, exp.cs, exp.cf);
    end
  endtask

  // Monitor: compare the DUT response mid-cycle against the scoreboard head.
  initial begin
    resp_t got, exp;
    string name;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp  = exp_q.pop_front();
        name = name_q.pop_front();
        got.ctl = {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.bubble_idex,
                   bus.flush_ifid, bus.flush_idex, bus.wb_bubble};
        got.err = bus.mmio_err;
        got.st  = bus.state_o;
        got.cs  = bus.cnt_stall;
        got.cf  = bus.cnt_flush;
        check(name, got, exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    stim_t s;
    step("reset",        '0,       mk(C_NONE, 0, 0, 0, 0));
    step("idle",         s_idle(), mk(C_NONE, 0, 0, 0, 0));

    // Load-use on rs2, rs1, and the non-hazard variants.
    step("lu_rs2",       s_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1), mk(C_LU,   0, 0, 0, 0));
    step("lu_release",   s_idle(),                           mk(C_NONE, 0, 0, 1, 0));
    step("lu_x0",        s_lu(5'd0, 5'd0, 1'b0, 5'd0, 1'b1), mk(C_NONE, 0, 0, 1, 0));
    step("lu_rs1",       s_lu(5'd9, 5'd9, 1'b1, 5'd3, 1'b0), mk(C_LU,   0, 0, 1, 0));
    step("lu_rs1_rel",   s_idle(),                           mk(C_NONE, 0, 0, 2, 0));
    step("lu_unused",    s_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0), mk(C_NONE, 0, 0, 2, 0));

    // Redirect with coincident load-use; FLUSH ignores a second redirect.
    step("redir_t",      s_redir(1'b1), mk(C_RDR,  0, 0, 2, 0));
    step("flush_t1",     s_redir(1'b1), mk(C_FL,   0, 1, 2, 1));
    step("redir_t2",     s_idle(),      mk(C_NONE, 0, 0, 2, 1));

    // MMIO access, ready arrives 4 cycles after the request.
    step("mmio_req",     s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 0, 2, 1));
    step("mmio_wait1",   s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 2, 3, 1));
    step("mmio_wait2",   s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 2, 4, 1));
    step("mmio_wait3",   s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 2, 5, 1));
    step("mmio_exit",    s_mmio(1'b1, 1'b0), mk(C_NONE, 0, 2, 6, 1));
    step("mmio_done",    s_idle(),           mk(C_NONE, 0, 0, 6, 1));

    // MMIO block outranks load-use; load-use is honoured on the exit cycle.
    step("mmio_dep_req", s_mmio(1'b0, 1'b1), mk(C_MMIO, 0, 0, 6, 1));
    step("mmio_dep_ext", s_mmio(1'b1, 1'b1), mk(C_LU,   0, 2, 7, 1));
    step("mmio_dep_end", s_idle(),           mk(C_NONE, 0, 0, 8, 1));

    // Timeout: 8 cycles in MMIO_WAIT, stall counter saturates on the way.
    step("to_entry",     s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 0, 8, 1));
    for (int k = 1; k <= 7; k++)
      step("to_wait",    s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 2, sat(8 + k), 1));
    step("to_hit",       s_mmio(1'b0, 1'b0), mk(C_NONE, 0, 2, 15, 1));
    step("to_err",       s_idle(),           mk(C_NONE, 1, 0, 15, 1));
    step("to_err_clr",   s_idle(),           mk(C_NONE, 0, 0, 15, 1));

    // Asynchronous reset while in MMIO_WAIT, checked before the next edge.
    step("rst_pre_req",  s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 0, 15, 1));
    step("rst_pre_wait", s_mmio(1'b0, 1'b0), mk(C_MMIO, 0, 2, 15, 1));
    s = s_idle();
    s.rst_n = 1'b0;
    step("rst_async",    s,                  mk(C_NONE, 0, 0, 0, 0));
    step("rst_release",  s_idle(),           mk(C_NONE, 0, 0, 0, 0));

    // Twenty load-use stalls into a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      step("sat_lu",  s_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1), mk(C_LU,   0, 0, sat(k),     0));
      step("sat_gap", s_idle(),                           mk(C_NONE, 0, 0, sat(k + 1), 0));
    end
    step("sat_hold",     s_idle(), mk(C_NONE, 0, 0, 15, 0));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
